// File: rtl/hdr_stream_pkg.sv
// rtl/hdr_stream_pkg.sv - shared types and constants for the dual-exposure stream aligner
package hdr_stream_pkg;

  localparam int PIX_W = 8;

  typedef struct packed {
    logic             sop;
    logic             eop;
    logic [PIX_W-1:0] data;
  } pix_word_t;

  localparam int PIX_WORD_W = $bits(pix_word_t);

  typedef enum logic {
    S_HUNT = 1'b0,
    S_RUN  = 1'b1
  } align_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO, power-of-two depth, extra-MSB full/empty
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Same index with differing wrap bits means the write side has lapped the read side.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dual_stream_align.sv
// rtl/dual_stream_align.sv - aligns two exposure pixel streams frame by frame; DUAL_STREAM_ALIGN_STATS_EN enables counters
module dual_stream_align
  import hdr_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PIX_W-1:0] cam0_data,
  input  logic             cam0_valid,
  input  logic             cam0_sop,
  input  logic             cam0_eop,
  input  logic [PIX_W-1:0] cam1_data,
  input  logic             cam1_valid,
  input  logic             cam1_sop,
  input  logic             cam1_eop,
  input  logic             clear_status,
  output logic [PIX_W-1:0] raw_data_0,
  output logic [PIX_W-1:0] raw_data_1,
  output logic             raw_data_valid,
  output logic             raw_data_sop,
  output logic             raw_data_eop,
  output logic             align_err,
  output logic             overflow_0,
  output logic             overflow_1,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       err_cnt
);

  pix_word_t    wr0, wr1, head0, head1;
  logic         full0, full1, empty0, empty1;
  logic         pop0, pop1, both, match, ovf0, ovf1;
  align_state_t state;

  assign wr0 = {cam0_sop, cam0_eop, cam0_data};
  assign wr1 = {cam1_sop, cam1_eop, cam1_data};

  sync_fifo #(.WIDTH(PIX_WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk), .reset_n(reset_n), .wr_en(cam0_valid), .wr_data(wr0),
    .rd_en(pop0), .rd_data(head0), .full(full0), .empty(empty0)
  );

  sync_fifo #(.WIDTH(PIX_WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .reset_n(reset_n), .wr_en(cam1_valid), .wr_data(wr1),
    .rd_en(pop1), .rd_data(head1), .full(full1), .empty(empty1)
  );

  assign ovf0  = cam0_valid && full0;
  assign ovf1  = cam1_valid && full1;
  assign both  = !empty0 && !empty1;
  assign match = (head0.sop == head1.sop) && (head0.eop == head1.eop);

  // Hunting drains each side independently up to its next sop; running only ever pops in pairs.
  always_comb begin
    pop0 = 1'b0;
    pop1 = 1'b0;
    if (state == S_HUNT) begin
      pop0 = !empty0 && !head0.sop;
      pop1 = !empty1 && !head1.sop;
    end else begin
      pop0 = both;
      pop1 = both;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_HUNT;
      raw_data_0     <= '0;
      raw_data_1     <= '0;
      raw_data_valid <= 1'b0;
      raw_data_sop   <= 1'b0;
      raw_data_eop   <= 1'b0;
      align_err      <= 1'b0;
      overflow_0     <= 1'b0;
      overflow_1     <= 1'b0;
    end else begin
      raw_data_valid <= 1'b0;
      align_err      <= 1'b0;
      case (state)
        S_HUNT: begin
          if (both && head0.sop && head1.sop)
            state <= S_RUN;
        end
        S_RUN: begin
          if (both) begin
            if (match) begin
              raw_data_valid <= 1'b1;
              raw_data_0     <= head0.data;
              raw_data_1     <= head1.data;
              raw_data_sop   <= head0.sop;
              raw_data_eop   <= head0.eop;
              if (head0.eop)
                state <= S_HUNT;
            end else begin
              align_err <= 1'b1;
              state     <= S_HUNT;
            end
          end
        end
        default: state <= S_HUNT;
      endcase
      // A dropped write breaks the pairing, so resynchronise on the next sop.
      if (ovf0 || ovf1)
        state <= S_HUNT;
      if (ovf0)
        overflow_0 <= 1'b1;
      else if (clear_status)
        overflow_0 <= 1'b0;
      if (ovf1)
        overflow_1 <= 1'b1;
      else if (clear_status)
        overflow_1 <= 1'b0;
    end
  end

`ifdef DUAL_STREAM_ALIGN_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (raw_data_valid && raw_data_eop)
        frame_cnt <= frame_cnt + 16'd1;
      if (align_err && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: doc/dual_stream_align.md
DUAL_STREAM_ALIGN -- requirements
Module: dual_stream_align

Interface
REQ-001 FIFO_DEPTH, 1024, entries per channel FIFO; power of two, minimum 4.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 cam0_data / cam1_data  input  8 each  pixel from exposure 0 / exposure 1.
REQ-005 cam0_valid, cam0_sop, cam0_eop / cam1_valid, cam1_sop, cam1_eop  input  1 each  per-channel strobes; sop and eop are qualified by valid.
REQ-006 clear_status  input  1  synchronous clear of the sticky flags.
REQ-007 raw_data_0, raw_data_1  output  8 each  aligned pixel pair, fed to the gamma stage.
REQ-008 raw_data_valid, raw_data_sop, raw_data_eop  output  1 each  aligned strobes.
REQ-009 align_err  output  1  one-cycle pulse on sop/eop mismatch.
REQ-010 overflow_0, overflow_1  output  1 each  sticky FIFO overflow flags.
REQ-011 frame_cnt  output  16  emitted-frame counter.
REQ-012 err_cnt  output  8  alignment-error counter.

Function
REQ-013 Each channel SHALL write {sop,eop,data} into its own show-ahead FIFO whenever its valid is high and the FIFO is not full.
REQ-014 A write to a full FIFO SHALL be dropped; the matching overflow_x flag SHALL be set, and the FSM SHALL enter S_HUNT on the next cycle.
REQ-015 FSM states SHALL be S_HUNT and S_RUN; the reset state is S_HUNT.
REQ-016 S_HUNT: every non-empty FIFO whose head has sop=0 SHALL be popped and its entry discarded; no output is produced.
REQ-017 S_HUNT -> S_RUN SHALL occur in the cycle in which both heads have sop=1; neither FIFO is popped in that cycle.
REQ-018 S_RUN: both FIFOs SHALL be popped together only when both are non-empty; a single-sided pop is forbidden.
REQ-019 For a popped pair with equal sop bits and equal eop bits, the outputs SHALL be registered on the next edge:
- valid=1
- raw_data_0 and raw_data_1 from channels 0 and 1
- sop and eop from channel 0
REQ-020 A popped pair with a sop or eop mismatch SHALL NOT be emitted; align_err SHALL pulse for one cycle and the FSM SHALL return to S_HUNT.
REQ-021 After emitting a pair with eop=1, the FSM SHALL return to S_HUNT.
REQ-022 raw_data_valid SHALL be 0 in any cycle with no emission; data outputs hold their last value.
REQ-023 Latency from the later of the two input writes to the output SHALL be 2 cycles while in S_RUN (1 cycle FIFO write, 1 cycle output register).
REQ-024 The output SHALL NOT be throttled; there is no backpressure input.
REQ-025 If clear_status and a new overflow occur in the same cycle, set SHALL win.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Full and empty SHALL be distinguished by an extra pointer MSB.

Reset
REQ-027 On reset_n low, all of the following SHALL be cleared asynchronously:
- both FIFOs emptied
- FSM set to S_HUNT
- all outputs, flags and counters set to 0
REQ-028 Reset asserted mid-frame SHALL discard all buffered data; after release, output resumes only at the next sop pair.

Configuration
REQ-029 Macro DUAL_STREAM_ALIGN_STATS_EN defined: frame_cnt SHALL increment on each emitted eop and wrap at 16 bits, and err_cnt SHALL increment on each align_err and saturate at 255.
REQ-030 Macro DUAL_STREAM_ALIGN_STATS_EN undefined: frame_cnt and err_cnt SHALL remain as ports tied to 0, with no counter logic.

Structure
REQ-031 Shared package hdr_stream_pkg SHALL hold:
- typedef pix_word_t as a packed {sop,eop,data[7:0]}
- the FSM enum align_state_t
- the constant PIX_W=8
REQ-032 The FIFO SHALL be one sub-module, sync_fifo: show-ahead, parameterised by width and depth, instantiated twice.

Verification
REQ-033 Two identical 4x2 frames, cam1 delayed 5 cycles -> 8 output beats; first beat 2 cycles after cam1's first write; sop on beat 1, eop on beat 8; frame_cnt=1.
REQ-034 cam0 sends 3 garbage pixels (sop=0) before its frame -> garbage discarded; output identical to REQ-033.
REQ-035 cam1 eop one pixel early versus cam0 -> align_err pulses once; the mismatched pair is not emitted; err_cnt=1; the next frame pair is emitted correctly.
REQ-036 FIFO_DEPTH=4 with cam1 idle while cam0 sends 6 pixels -> overflow_0=1 and stays set; clear_status clears it; FSM in S_HUNT.
REQ-037 reset_n pulsed low mid-frame -> all outputs 0 immediately; the partial frame is never emitted; the next full frame pair is emitted correctly.
